fully_connected_layer_3: RTL and testbench
==========================================

Name: fully_connected_layer_3

Overview:
- Final LeNet classifier layer: 84-element feature vector in, 10 class scores out, computed as signed fixed-point dot products plus bias.
- Sits directly upstream of the final ReLU activation stage and drives its 10 x 32-bit featuremap input.
- Uses one time-multiplexed multiply-accumulate unit, fed from a synchronous single-port weight/bias ROM outside the block.

Parameters:
- bitwidth, 32, width of every activation, weight, bias and output word (signed two's complement).
- IN_LEN, 84, number of input features.
- OUT_LEN, 10, number of output neurons.
- FRAC, 16, number of fractional bits (Q15.16 at default width).
- ADDR_W, 10, ROM address width; must satisfy 2^ADDR_W >= OUT_LEN*IN_LEN + OUT_LEN.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a computation; sampled only in IDLE.
- featuremap  input  bitwidth x [IN_LEN-1:0]  84 input activations.
- weight_rd_en  output  1  ROM read strobe.
- weight_addr  output  ADDR_W  ROM address.
- weight_data  input  bitwidth  ROM read data, valid the cycle after a strobed address.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse when all outputs are updated.
- featuremap_out  output  bitwidth x [OUT_LEN-1:0]  10 class scores, registered.

Behaviour:
- Reset: state IDLE. busy=0, done=0, weight_rd_en=0, weight_addr=0, all featuremap_out=0, accumulator and counters 0.
- ROM map:
  - weight for neuron o, input i at address o*IN_LEN + i.
  - bias for neuron o at address OUT_LEN*IN_LEN + o (840..849).
- Start acceptance: in IDLE, start=1 is sampled at an edge. That edge snapshots featuremap into an internal register, sets busy=1 and moves to BIAS with o=0. start is ignored while busy.
- BIAS, 1 cycle: assert weight_rd_en with the bias address for neuron o, then go to MAC with i=0.
- MAC, IN_LEN cycles: each cycle assert weight_rd_en with the weight address for (o, i), incrementing i.
  - The cycle after the bias read, the accumulator loads sign-extended bias.
  - The cycle after each weight read, the accumulator adds (snap[i-1] * weight_data) >>> FRAC.
  - After i=IN_LEN-1 is issued, go to STORE.
- STORE, 1 cycle: weight_rd_en=0. Add the final product, saturate, write featuremap_out[o].
  - If o==OUT_LEN-1, go to DONE; otherwise o++ and return to BIAS.
- DONE, 1 cycle: done=1, busy=0, then IDLE.
- Per-neuron cost is IN_LEN+2 = 86 cycles. With start sampled at edge 0, done is high in the cycle after edge 860 (OUT_LEN*(IN_LEN+2)).
- featuremap_out[o] updates exactly at its STORE edge and holds until overwritten by a later run or cleared by rst.
- Arithmetic:
  - Product is the full 2*bitwidth signed product, arithmetic-shifted right by FRAC (floor).
  - Accumulator is 2*bitwidth signed and never wraps at the default sizes.
  - On store, saturate to [-2^(bitwidth-1), 2^(bitwidth-1)-1].
  - Negative results pass through unchanged; clamping is the next stage's job.
- weight_addr holds its last value when weight_rd_en=0; the ROM is never strobed outside BIAS/MAC.
- rst mid-run: immediate return to IDLE with all reset values, including featuremap_out=0. No done pulse. A start sampled the same edge as rst is ignored.
- start high in the DONE cycle is ignored; it is accepted in the following IDLE cycle if still high.

Test Plan:
- All weights 0, all biases 0x00050000, start pulse -> done exactly 860 cycles later; every featuremap_out = 0x00050000; busy high throughout.
- featuremap[i]=0x00010000 (1.0) for all i, weight(o,i)=0x00010000, bias(o)=o<<16 -> featuremap_out[o] = (84+o)<<16, e.g. out[9]=0x005D0000.
- featuremap all 0x7FFF0000, weights all 0x7FFF0000 -> every output = 0x7FFFFFFF; negated weights -> every output = 0x80000000.
- featuremap[0]=0xFFFF0000 (-1.0), weight(o,0)=0x00020000, all else 0 -> every output = 0xFFFE0000 (negative, unclamped).
- Address trace: the strobed sequence is 840,0..83,841,84..167,...,849,756..839, with exactly 850 strobes. Changing featuremap after start has no effect; start pulses while busy produce no second run.
- Assert rst at cycle 300 of a run -> next cycle busy=0, all outputs 0, no done. A fresh start then completes normally with correct values.

Source files
------------

// File: rtl/fully_connected_layer_3.sv
// fully_connected_layer_3
// Final LeNet classifier layer: 84 input activations -> 10 class scores.
// One multiply-accumulate unit is time-shared across all neurons. Weights
// and biases come from an external synchronous ROM, one word per cycle.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   start           request a run; sampled only while idle
//   featuremap      IN_LEN signed activations, snapshotted when a run starts
//   weight_rd_en    ROM read strobe
//   weight_addr     ROM address (holds its last value while not strobing)
//   weight_data     ROM data, valid the cycle after a strobed address
//   busy            high while a run is in progress
//   done            one-cycle pulse once every output has been written
//   featuremap_out  OUT_LEN signed, saturated class scores (registered)
//
// ROM layout: weight(o,i) at o*IN_LEN+i, bias(o) at OUT_LEN*IN_LEN+o.
module fully_connected_layer_3 #(
    parameter int bitwidth = 32,
    parameter int IN_LEN   = 84,
    parameter int OUT_LEN  = 10,
    parameter int FRAC     = 16,
    parameter int ADDR_W   = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [IN_LEN-1:0][bitwidth-1:0]   featuremap,
    output logic                              weight_rd_en,
    output logic [ADDR_W-1:0]                 weight_addr,
    input  logic [bitwidth-1:0]               weight_data,
    output logic                              busy,
    output logic                              done,
    output logic [OUT_LEN-1:0][bitwidth-1:0]  featuremap_out
);

    localparam int I_W = (IN_LEN  > 1) ? $clog2(IN_LEN)  : 1;
    localparam int O_W = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
    localparam int AW  = 2 * bitwidth;

    localparam logic [I_W-1:0]    I_LAST    = I_W'(IN_LEN - 1);
    localparam logic [O_W-1:0]    O_LAST    = O_W'(OUT_LEN - 1);
    localparam logic [ADDR_W-1:0] BIAS_BASE = ADDR_W'(OUT_LEN * IN_LEN);

    // Saturation bounds of a bitwidth-wide signed word, in accumulator width.
    localparam logic signed [AW-1:0] SAT_MAX = {{(bitwidth+1){1'b0}}, {(bitwidth-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(bitwidth+1){1'b1}}, {(bitwidth-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_BIAS,
        S_MAC,
        S_STORE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [IN_LEN-1:0][bitwidth-1:0] snap;
    logic [I_W-1:0]                  i_cnt;    // index of the weight being strobed this cycle
    logic [O_W-1:0]                  o_cnt;    // neuron in progress
    logic [ADDR_W-1:0]               w_addr;   // next weight address, o*IN_LEN+i kept as a running count
    logic signed [AW-1:0]            acc;

    logic [I_W-1:0]       prev_idx;
    logic [bitwidth-1:0]  act_sel;
    logic signed [AW-1:0] a_ext;
    logic signed [AW-1:0] b_ext;
    logic signed [AW-1:0] full_prod;
    logic signed [AW-1:0] prod;
    logic signed [AW-1:0] sum;
    logic signed [AW-1:0] bias_ext;
    logic [bitwidth-1:0]  sat_val;

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_BIAS;
            S_BIAS:  state_nxt = S_MAC;
            S_MAC:   if (i_cnt == I_LAST) state_nxt = S_STORE;
            S_STORE: state_nxt = (o_cnt == O_LAST) ? S_DONE : S_BIAS;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state == S_BIAS) || (state == S_MAC) || (state == S_STORE);
    assign done = (state == S_DONE);

    // ---------------- MAC datapath ----------------
    // weight_data lags the strobe by one cycle, so the activation paired with
    // it is the one for the previous index; in STORE it is the last input.
    always_comb begin
        prev_idx  = (i_cnt == '0) ? '0 : i_cnt - 1'b1;
        act_sel   = (state == S_STORE) ? snap[IN_LEN-1] : snap[prev_idx];
        a_ext     = {{bitwidth{act_sel[bitwidth-1]}}, act_sel};
        b_ext     = {{bitwidth{weight_data[bitwidth-1]}}, weight_data};
        full_prod = a_ext * b_ext;
        prod      = full_prod >>> FRAC;
        sum       = acc + prod;
        bias_ext  = b_ext;
        if (sum > SAT_MAX)
            sat_val = {1'b0, {(bitwidth-1){1'b1}}};
        else if (sum < SAT_MIN)
            sat_val = {1'b1, {(bitwidth-1){1'b0}}};
        else
            sat_val = sum[bitwidth-1:0];
    end

    // ---------------- state, counters, ROM interface, outputs ----------------
    // The ROM strobe/address are registered: the value set at an edge is
    // the request presented during the state entered at that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            snap           <= '0;
            i_cnt          <= '0;
            o_cnt          <= '0;
            w_addr         <= '0;
            acc            <= '0;
            weight_rd_en   <= 1'b0;
            weight_addr    <= '0;
            featuremap_out <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        snap         <= featuremap;
                        o_cnt        <= '0;
                        w_addr       <= '0;
                        weight_rd_en <= 1'b1;
                        weight_addr  <= BIAS_BASE;
                    end
                end
                S_BIAS: begin
                    i_cnt        <= '0;
                    weight_rd_en <= 1'b1;
                    weight_addr  <= w_addr;
                    w_addr       <= w_addr + 1'b1;
                end
                S_MAC: begin
                    // First MAC cycle sees the bias word; later ones see weights.
                    acc <= (i_cnt == '0) ? bias_ext : sum;
                    if (i_cnt == I_LAST) begin
                        weight_rd_en <= 1'b0;
                    end else begin
                        i_cnt       <= i_cnt + 1'b1;
                        weight_addr <= w_addr;
                        w_addr      <= w_addr + 1'b1;
                    end
                end
                S_STORE: begin
                    featuremap_out[o_cnt] <= sat_val;
                    if (o_cnt != O_LAST) begin
                        o_cnt        <= o_cnt + 1'b1;
                        weight_rd_en <= 1'b1;
                        weight_addr  <= BIAS_BASE + ADDR_W'(o_cnt) + 1'b1;
                    end
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fully_connected_layer_3.sv
module tb_fully_connected_layer_3;

    localparam int IN  = 84;
    localparam int OUT = 10;
    localparam int NV  = 7;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [IN-1:0][31:0]   featuremap;
    logic                  weight_rd_en;
    logic [9:0]            weight_addr;
    logic [31:0]           weight_data;
    logic                  busy;
    logic                  done;
    logic [OUT-1:0][31:0]  featuremap_out;

    fully_connected_layer_3 dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .featuremap     (featuremap),
        .weight_rd_en   (weight_rd_en),
        .weight_addr    (weight_addr),
        .weight_data    (weight_data),
        .busy           (busy),
        .done           (done),
        .featuremap_out (featuremap_out)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model
    logic [31:0] rom [0:1023];
    always @(posedge clk) if (weight_rd_en) weight_data <= rom[weight_addr];

    // Strobe log, sampled mid-cycle
    logic [9:0] strobes[$];
    always @(negedge clk) if (weight_rd_en) strobes.push_back(weight_addr);

    // fm: activation for i>0 / i==0; w: weight for i>0 / i==0;
    // bias(o) = b_base + o*b_step; expected out[o] = e_base + o*e_step
    typedef struct {
        logic [31:0] fm_all, fm0, w_all, w0, b_base, b_step, e_base, e_step;
    } vec_t;
    vec_t vecs[NV];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic load(input int v);
        for (int a = 0; a < 1024; a++) rom[a] = '0;
        for (int o = 0; o < OUT; o++) begin
            for (int i = 0; i < IN; i++) rom[o*IN+i] = (i == 0) ? vecs[v].w0 : vecs[v].w_all;
            rom[OUT*IN+o] = vecs[v].b_base + 32'(o) * vecs[v].b_step;
        end
        for (int i = 0; i < IN; i++) featuremap[i] = (i == 0) ? vecs[v].fm0 : vecs[v].fm_all;
    endtask

    task automatic pulse_start;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Entered one sample after the accept edge; returns cycles until done.
    task automatic wait_done(input bit disturb, output int cyc, output int busy_bad);
        cyc = 0;
        busy_bad = 0;
        while (done !== 1'b1 && cyc < 2000) begin
            if (busy !== 1'b1) busy_bad++;
            if (disturb && cyc == 5)   featuremap = ~featuremap;
            if (disturb && cyc == 100) start = 1'b1;
            if (disturb && cyc == 101) start = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic check_outputs(input int v, input string tag);
        for (int o = 0; o < OUT; o++)
            chk($sformatf("%s_out%0d", tag, o), featuremap_out[o],
                vecs[v].e_base + 32'(o) * vecs[v].e_step);
    endtask

    task automatic do_run(input int v, input bit disturb);
        int cyc, bb, bad, idx;
        load(v);
        strobes.delete();
        pulse_start();
        wait_done(disturb, cyc, bb);
        chk($sformatf("v%0d_latency", v), 32'(cyc), 32'd860);
        chk($sformatf("v%0d_busy_during_run", v), 32'(bb), 32'd0);
        chk($sformatf("v%0d_busy_at_done", v), {31'd0, busy}, 32'd0);
        check_outputs(v, $sformatf("v%0d", v));
        repeat (5) begin @(posedge clk); #1; end
        chk($sformatf("v%0d_idle_after", v), {30'd0, busy, done}, 32'd0);
        chk($sformatf("v%0d_strobe_count", v), 32'(strobes.size()), 32'd850);
        bad = 0;
        idx = 0;
        if (strobes.size() == 850) begin
            for (int o = 0; o < OUT; o++) begin
                if (strobes[idx] != 10'(840 + o)) bad++;
                idx++;
                for (int i = 0; i < IN; i++) begin
                    if (strobes[idx] != 10'(o*IN + i)) bad++;
                    idx++;
                end
            end
        end else bad = 1;
        chk($sformatf("v%0d_addr_seq_errors", v), 32'(bad), 32'd0);
    endtask

    initial begin
        int cyc, bb, done_seen;
        vecs[0] = '{32'h00010000, 32'h00010000, 32'h0,        32'h0,        32'h00050000, 32'h0,     32'h00050000, 32'h0};
        vecs[1] = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h0,        32'h10000, 32'h00540000, 32'h10000};
        vecs[2] = '{32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h0,        32'h0,     32'h7FFFFFFF, 32'h0};
        vecs[3] = '{32'h7FFF0000, 32'h7FFF0000, 32'h80010000, 32'h80010000, 32'h0,        32'h0,     32'h80000000, 32'h0};
        vecs[4] = '{32'h0,        32'hFFFF0000, 32'h0,        32'h00020000, 32'h0,        32'h0,     32'hFFFE0000, 32'h0};
        vecs[5] = '{32'h00008000, 32'h00008000, 32'h00030000, 32'h00030000, 32'hFFFF0000, 32'h0,     32'h007D0000, 32'h0};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0,        32'h0,     32'hFFFFFFAC, 32'h0};

        rst = 1'b1;
        start = 1'b0;
        featuremap = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_rd_en", {31'd0, weight_rd_en}, 32'd0);
        chk("reset_addr", {22'd0, weight_addr}, 32'd0);
        chk("reset_out_nonzero", {31'd0, |featuremap_out}, 32'd0);
        rst = 1'b0;

        // Table of directed vectors; vector 1 also gets featuremap changes
        // and a stray start pulse mid-run.
        for (int v = 0; v < NV; v++) do_run(v, v == 1);

        // Start held high through DONE: ignored there, accepted in IDLE.
        load(1);
        pulse_start();
        wait_done(1'b0, cyc, bb);
        chk("seq_done_latency", 32'(cyc), 32'd860);
        start = 1'b1;
        @(posedge clk); #1;
        chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        chk("start_after_done_accepted", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done(1'b0, cyc, bb);
        chk("restart_latency", 32'(cyc), 32'd860);
        check_outputs(1, "restart");

        // Reset at cycle 300 of a run, with start asserted on the same edge.
        load(2);
        pulse_start();
        repeat (300) begin @(posedge clk); #1; end
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_rd_en", {31'd0, weight_rd_en}, 32'd0);
        chk("midrst_addr", {22'd0, weight_addr}, 32'd0);
        chk("midrst_out_nonzero", {31'd0, |featuremap_out}, 32'd0);
        done_seen = 0;
        repeat (900) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        chk("midrst_no_activity", 32'(done_seen), 32'd0);
        do_run(5, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
